// File: rtl/fft_r2_scheduler.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT through one shared butterfly.
// Issues one sample-pair read per cycle; twiddle and write-back addresses ride a LAT-deep delay line.
module fft_r2_scheduler #(
    parameter int LOGN    = 6,
    parameter int MEM_LAT = 1,
    parameter int BF_LAT  = 1,
    localparam int SW     = $clog2(LOGN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [SW-1:0]   stage,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr0,
    output logic [LOGN-1:0] rd_addr1,
    output logic            bf_valid,
    output logic [LOGN-2:0] tw_idx,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr0,
    output logic [LOGN-1:0] wr_addr1
);
    localparam int LAT = MEM_LAT + BF_LAT;
    localparam int KW  = LOGN - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [KW-1:0]            k;
    logic [SW-1:0]            stage_q;
    logic [LAT:1]             vld_pipe;
    logic [LAT:1][LOGN-1:0]   a0_pipe;
    logic [LAT:1][LOGN-1:0]   a1_pipe;
    logic [MEM_LAT:1][KW-1:0] tw_pipe;

    logic                     issue;
    logic                     last_k;
    logic                     last_stage;
    logic                     tail_empty;
    logic [LOGN-1:0]          kx, half, pos, grp, a0, a1;
    logic [KW-1:0]            tw;

    assign issue      = (state == RUN) && !hold;
    assign last_k     = &k;
    assign last_stage = (stage_q == SW'(LOGN - 1));
    // Nothing younger than the entry now at write-back: the stage has fully drained.
    assign tail_empty = (vld_pipe[LAT-1:1] == '0);

    always_comb begin
        kx   = {1'b0, k};
        half = LOGN'(1) << stage_q;
        pos  = kx & (half - 1'b1);
        grp  = kx >> stage_q;
        a0   = ((grp << stage_q) << 1) + pos;
        a1   = a0 + half;
        tw   = pos[KW-1:0] << (SW'(LOGN - 1) - stage_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            stage_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    k       <= '0;
                    stage_q <= '0;
                end
                RUN: if (!hold) begin
                    k <= k + 1'b1;
                    if (last_k) state <= DRAIN;
                end
                // Next stage may not read until the last write of this one has landed.
                DRAIN: if (vld_pipe[LAT] && tail_empty) begin
                    if (last_stage) begin
                        state <= DONE;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                        state   <= RUN;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    stage_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            a0_pipe  <= '0;
            a1_pipe  <= '0;
            tw_pipe  <= '0;
        end else begin
            vld_pipe[1] <= issue;
            a0_pipe[1]  <= a0;
            a1_pipe[1]  <= a1;
            tw_pipe[1]  <= tw;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a0_pipe[i]  <= a0_pipe[i-1];
                a1_pipe[i]  <= a1_pipe[i-1];
            end
            for (int i = 2; i <= MEM_LAT; i++) tw_pipe[i] <= tw_pipe[i-1];
        end
    end

    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign stage    = stage_q;
    assign rd_en    = issue;
    assign rd_addr0 = issue ? a0 : '0;
    assign rd_addr1 = issue ? a1 : '0;
    assign bf_valid = vld_pipe[MEM_LAT];
    assign tw_idx   = vld_pipe[MEM_LAT] ? tw_pipe[MEM_LAT] : '0;
    assign wr_en    = vld_pipe[LAT];
    assign wr_addr0 = vld_pipe[LAT] ? a0_pipe[LAT] : '0;
    assign wr_addr1 = vld_pipe[LAT] ? a1_pipe[LAT] : '0;
endmodule

// File: tb/tb_fft_r2_scheduler.sv
// Scoreboard bench: a cycle-level plan of every read/butterfly/write event is queued per transform,
// and a negedge monitor pops and compares; a behavioural RAM + butterfly checks final contents.
module tb_fft_r2_scheduler;
    localparam int LOGN = 3;
    localparam int ML   = 1;
    localparam int BL   = 1;
    localparam int LAT  = ML + BL;
    localparam int N    = 1 << LOGN;
    localparam int SW   = $clog2(LOGN);
    localparam int MAXC = 4096;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
    logic busy, done, rd_en, bf_valid, wr_en;
    logic [SW-1:0]   stage;
    logic [LOGN-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [LOGN-2:0] tw_idx;

    fft_r2_scheduler #(.LOGN(LOGN), .MEM_LAT(ML), .BF_LAT(BL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .bf_valid(bf_valid), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    typedef struct {int t; int s; int a0; int a1; int tw;} ev_t;

    ev_t         exp_rd[$], exp_bf[$], exp_wr[$];
    logic [31:0] dq1[$], dq2[$];
    logic [15:0] ram[N];
    logic [15:0] refm[N];
    bit          hold_abs[MAXC];
    bit          busy_exp[MAXC];
    bit          done_exp[MAXC];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #2;
        hold = (cyc < MAXC) ? hold_abs[cyc] : 1'b0;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic logic [31:0] bfly(input logic [15:0] a, input logic [15:0] b, input int tw);
        logic [15:0] w, p, o0, o1;
        w  = 16'(tw + 1);
        p  = b * w;
        o0 = a + p;
        o1 = a - p;
        return {o0, o1};
    endfunction

    task automatic addr_of(input int s, input int k, output int a0, output int a1, output int tw);
        int half, pos;
        half = 1 << s;
        pos  = k % half;
        a0   = (k / half) * 2 * half + pos;
        a1   = a0 + half;
        tw   = pos * ((N / 2) / half);
    endtask

    task automatic ref_fft();
        int a0, a1, tw;
        logic [31:0] r;
        for (int i = 0; i < N; i++) refm[i] = ram[i];
        for (int s = 0; s < LOGN; s++)
            for (int k = 0; k < N / 2; k++) begin
                addr_of(s, k, a0, a1, tw);
                r = bfly(refm[a0], refm[a1], tw);
                refm[a0] = r[31:16];
                refm[a1] = r[15:0];
            end
    endtask

    // Timeline from the start-sample cycle: one read per unheld cycle, LAT drain between stages.
    task automatic plan(input int base, output int dn);
        int t, last;
        ev_t e;
        t = base + 1;
        last = t;
        for (int s = 0; s < LOGN; s++) begin
            for (int k = 0; k < N / 2; k++) begin
                while (t < MAXC && hold_abs[t]) t++;
                e.t = t; e.s = s;
                addr_of(s, k, e.a0, e.a1, e.tw);
                exp_rd.push_back(e);
                e.t = t + ML;  exp_bf.push_back(e);
                e.t = t + LAT; exp_wr.push_back(e);
                last = t;
                t++;
            end
            t = last + LAT + 1;
        end
        dn = last + LAT + 1;
        for (int c = base + 1; c < dn && c < MAXC; c++) busy_exp[c] = 1'b1;
        if (dn < MAXC) done_exp[dn] = 1'b1;
    endtask

    task automatic set_hold(input int base, input int mode);
        for (int c = base; c < base + 600 && c < MAXC; c++)
            hold_abs[c] = (mode == 2) ? ($urandom_range(99) < 20)
                                      : (mode == 1 && c >= base + 2 && c <= base + 4);
    endtask

    task automatic load_ram();
        for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
    endtask

    task automatic check_ram();
        for (int i = 0; i < N; i++) chk($sformatf("ram[%0d]", i), int'(ram[i]), int'(refm[i]));
    endtask

    task automatic check_drained();
        chk("rd_left", exp_rd.size(), 0);
        chk("bf_left", exp_bf.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 1000);
        chk("done_seen", int'(done), 1);
        dc = cyc;
    endtask

    // mode 0: no hold, 1: hold in relative cycles 2-4, 2: random 20% hold
    task automatic do_run(input int mode, output int doff);
        int base, dexp, dgot;
        @(posedge clk);
        #1;
        base = cyc;
        set_hold(base, mode);
        load_ram();
        ref_fft();
        plan(base, dexp);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dgot);
        chk("done_cycle", dgot, dexp);
        check_ram();
        check_drained();
        doff = dgot - base;
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        logic [31:0] d;
        if (mon_en && cyc < MAXC) begin
            chk("busy", int'(busy), int'(busy_exp[cyc]));
            chk("done", int'(done), int'(done_exp[cyc]));
            if (rd_en) begin
                if (exp_rd.size() == 0) chk("rd_extra", exp_rd.size(), 1);
                else begin
                    e = exp_rd.pop_front();
                    chk("rd_cycle", cyc, e.t);
                    chk("rd_stage", int'(stage), e.s);
                    chk("rd_addr0", int'(rd_addr0), e.a0);
                    chk("rd_addr1", int'(rd_addr1), e.a1);
                end
                dq1.push_back({ram[rd_addr0], ram[rd_addr1]});
            end
            if (bf_valid) begin
                if (exp_bf.size() == 0) chk("bf_extra", exp_bf.size(), 1);
                else begin
                    e = exp_bf.pop_front();
                    chk("bf_cycle", cyc, e.t);
                    chk("tw_idx", int'(tw_idx), e.tw);
                end
                if (dq1.size() > 0) begin
                    d = dq1.pop_front();
                    dq2.push_back(bfly(d[31:16], d[15:0], int'(tw_idx)));
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) chk("wr_extra", exp_wr.size(), 1);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_cycle", cyc, e.t);
                    chk("wr_addr0", int'(wr_addr0), e.a0);
                    chk("wr_addr1", int'(wr_addr1), e.a1);
                end
                if (dq2.size() > 0) begin
                    d = dq2.pop_front();
                    ram[wr_addr0] = d[31:16];
                    ram[wr_addr1] = d[15:0];
                end
            end
        end
    end

    function automatic int all_outs();
        return int'({busy, done, stage, rd_en, rd_addr0, rd_addr1,
                     bf_valid, tw_idx, wr_en, wr_addr0, wr_addr1});
    endfunction

    initial begin
        int d, base, dexp1, dexp2;
        #12;
        chk("reset_outs", all_outs(), 0);
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        do_run(0, d);
        chk("single_done_off", d, 1 + LOGN * (N / 2 + LAT));
        do_run(1, d);
        chk("hold_done_off", d, 4 + LOGN * (N / 2 + LAT));

        // start held high: one transform, then a second begins from the IDLE cycle after done
        @(posedge clk);
        #1;
        base = cyc;
        set_hold(base, 0);
        load_ram();
        ref_fft();
        plan(base, dexp1);
        plan(dexp1 + 1, dexp2);
        start = 1'b1;
        wait_done(d);
        chk("held_done_off", d - base, 1 + LOGN * (N / 2 + LAT));
        check_ram();
        while (cyc < base + 23) begin
            @(posedge clk);
            #3;
        end
        chk("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 0);
        mon_en = 1'b0;
        start  = 1'b0;
        exp_rd.delete(); exp_bf.delete(); exp_wr.delete();
        dq1.delete(); dq2.delete();
        for (int c = cyc; c < MAXC; c++) begin
            busy_exp[c] = 1'b0;
            done_exp[c] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #3;
        chk("abort_outs_held", all_outs(), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        do_run(0, d);
        chk("post_reset_done_off", d, 1 + LOGN * (N / 2 + LAT));
        repeat (4) do_run(2, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
